// File: rtl/arcade_ctrl_mapper.sv
// Player-control front end: merges keyboard and MiST joysticks, rotates, shapes coins.
// Optional autofire is compiled in when the AUTOFIRE_EN macro is defined.
module arcade_ctrl_mapper #(
   parameter int NPLAYERS    = 2,
   parameter int SHARED_CTRL = 1,
   parameter int COIN_PULSE  = 18000,
   parameter int COIN_GAP    = 90000,
   parameter int AF_HALF     = 900000
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic [1:0]              rotate,
   input  logic [9:0]              kbjoy,
   input  logic [8*NPLAYERS-1:0]   joy_in,
   input  logic                    af_enable,
   output logic [7*NPLAYERS-1:0]   p_csjudlr,
   output logic                    coin_busy
);

   localparam int MAXC = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
   localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
   localparam logic [CW-1:0] P_LAST = CW'(COIN_PULSE - 1);
   localparam logic [CW-1:0] G_LAST = (COIN_GAP > 0) ? CW'(COIN_GAP - 1) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_st_t;

   // {fire,U,D,L,R} vectors
   logic [4:0]                kb_v;
   logic [4:0]                all_v;
   logic [NPLAYERS-1:0][4:0]  raw;
   logic [NPLAYERS-1:0]       fire_nx;
   logic [NPLAYERS-1:0]       start_nx;

   logic [NPLAYERS-1:0][3:0]  dir_q;
   logic [NPLAYERS-1:0]       fire_q;
   logic [NPLAYERS-1:0]       start_q;

   coin_st_t                  coin_st;
   logic [CW-1:0]             coin_cnt;
   logic                      coin_q;
   logic                      coin_prev;
   logic                      coin_armed;
   logic                      coin_edge_q;

   logic [NPLAYERS-1:0][2:0]  unused_joy_hi;

   assign kb_v = {kbjoy[0], kbjoy[4], kbjoy[5], kbjoy[6], kbjoy[7]};

   // Rotate {U,D,L,R} for the cabinet orientation
   function automatic logic [3:0] rot_dir(input logic [1:0] r,
                                          input logic [3:0] v);
      logic u, d, l, rr;
      logic [3:0] o;
      u  = v[3];
      d  = v[2];
      l  = v[1];
      rr = v[0];
      case (r)
         2'd0:    o = {u, d, l, rr};
         2'd1:    o = {l, rr, d, u};
         2'd2:    o = {d, u, rr, l};
         default: o = {rr, l, u, d};
      endcase
      return o;
   endfunction

   // Merge sources into per-player raw controls
   always_comb begin
      all_v = kb_v;
      raw   = '0;
      for (int n = 0; n < NPLAYERS; n++)
         all_v = all_v | joy_in[8*n +: 5];
      for (int n = 0; n < NPLAYERS; n++) begin
         if (SHARED_CTRL != 0)
            raw[n] = all_v;
         else if (n == 0)
            raw[n] = joy_in[8*n +: 5] | kb_v;
         else
            raw[n] = joy_in[8*n +: 5];
      end
   end

   // Start buttons exist for the first two players only
   always_comb begin
      start_nx = '0;
      for (int n = 0; n < NPLAYERS; n++)
         start_nx[n] = (n == 0) ? kbjoy[1] :
                       (n == 1) ? kbjoy[2] : 1'b0;
   end

   // Joystick bits [7:5] carry nothing for these cores
   always_comb begin
      unused_joy_hi = '0;
      for (int n = 0; n < NPLAYERS; n++)
         unused_joy_hi[n] = joy_in[8*n+5 +: 3];
   end

`ifdef AUTOFIRE_EN
   localparam int AW = (AF_HALF < 2) ? 1 : $clog2(AF_HALF + 1);
   localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF - 1);

   // af_off = 1 marks the silent half of the autofire period
   logic [NPLAYERS-1:0][AW-1:0] af_cnt;
   logic [NPLAYERS-1:0]         af_off;
   logic [NPLAYERS-1:0]         af_off_nx;
   logic [NPLAYERS-1:0]         af_wrap;
   logic [NPLAYERS-1:0]         fire_prev;
   logic [NPLAYERS-1:0]         fire_edge;
   logic [1:0]                  unused_kb;

   assign unused_kb = kbjoy[9:8];

   // Next autofire phase; a new press restarts on the firing half
   always_comb begin
      af_off_nx = '0;
      af_wrap   = '0;
      fire_edge = '0;
      fire_nx   = '0;
      for (int n = 0; n < NPLAYERS; n++) begin
         fire_edge[n] = raw[n][4] & ~fire_prev[n];
         af_wrap[n]   = (af_cnt[n] == AF_LAST);
         if (fire_edge[n])
            af_off_nx[n] = 1'b0;
         else if (af_wrap[n])
            af_off_nx[n] = ~af_off[n];
         else
            af_off_nx[n] = af_off[n];
         fire_nx[n] = raw[n][4] & ~(af_enable & af_off_nx[n]);
      end
   end

   // Free-running autofire counters, realigned on each press
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         af_cnt    <= '0;
         af_off    <= '0;
         fire_prev <= '0;
      end else begin
         for (int n = 0; n < NPLAYERS; n++) begin
            fire_prev[n] <= raw[n][4];
            af_off[n]    <= af_off_nx[n];
            if (fire_edge[n] || af_wrap[n])
               af_cnt[n] <= '0;
            else
               af_cnt[n] <= af_cnt[n] + AW'(1);
         end
      end
   end
`else
   logic [2:0] unused_kb;

   assign unused_kb = {af_enable, kbjoy[9:8]};

   // Fire passes straight through from the merged sources
   always_comb begin
      fire_nx = '0;
      for (int n = 0; n < NPLAYERS; n++)
         fire_nx[n] = raw[n][4];
   end
`endif

   // Register rotated directions, fire and start per player
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dir_q   <= '0;
         fire_q  <= '0;
         start_q <= '0;
      end else begin
         for (int n = 0; n < NPLAYERS; n++) begin
            dir_q[n]   <= rot_dir(rotate, raw[n][3:0]);
            fire_q[n]  <= fire_nx[n];
            start_q[n] <= start_nx[n];
         end
      end
   end

   // Coin edge detect; not armed until one clock after reset so a held key is ignored
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         coin_prev   <= 1'b0;
         coin_armed  <= 1'b0;
         coin_edge_q <= 1'b0;
      end else begin
         coin_prev   <= kbjoy[3];
         coin_armed  <= 1'b1;
         coin_edge_q <= coin_armed & kbjoy[3] & ~coin_prev;
      end
   end

   // Coin shaper: fixed pulse then hold-off, edges outside IDLE dropped
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         coin_st   <= IDLE;
         coin_cnt  <= '0;
         coin_q    <= 1'b0;
         coin_busy <= 1'b0;
      end else begin
         case (coin_st)
            IDLE: begin
               coin_cnt <= '0;
               if (coin_edge_q) begin
                  coin_st   <= PULSE;
                  coin_q    <= 1'b1;
                  coin_busy <= 1'b1;
               end
            end
            PULSE: begin
               if (coin_cnt == P_LAST) begin
                  coin_cnt <= '0;
                  coin_q   <= 1'b0;
                  if (COIN_GAP == 0) begin
                     coin_st   <= IDLE;
                     coin_busy <= 1'b0;
                  end else begin
                     coin_st <= GAP;
                  end
               end else begin
                  coin_cnt <= coin_cnt + CW'(1);
               end
            end
            GAP: begin
               if (coin_cnt == G_LAST) begin
                  coin_cnt  <= '0;
                  coin_st   <= IDLE;
                  coin_busy <= 1'b0;
               end else begin
                  coin_cnt <= coin_cnt + CW'(1);
               end
            end
            default: begin
               coin_st   <= IDLE;
               coin_cnt  <= '0;
               coin_q    <= 1'b0;
               coin_busy <= 1'b0;
            end
         endcase
      end
   end

   // Pack player slices as {coin,start,fire,U,D,L,R}
   always_comb begin
      p_csjudlr = '0;
      for (int n = 0; n < NPLAYERS; n++)
         p_csjudlr[7*n +: 7] = {(n == 0) ? coin_q : 1'b0,
                                start_q[n], fire_q[n], dir_q[n]};
   end

endmodule

// File: tb/tb_arcade_ctrl_mapper.sv
// Bench for arcade_ctrl_mapper: two instances (private and shared control).
// Vector table plus cycle sequences for coin, reset and fire behaviour.
module tb_arcade_ctrl_mapper;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rotate;
   logic [9:0]  kbjoy;
   logic [15:0] joy_a;
   logic [23:0] joy_b;
   logic        af_enable;
   logic [13:0] p_a;
   logic [20:0] p_b;
   logic        busy_a;
   logic        busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arcade_ctrl_mapper #(
      .NPLAYERS(2), .SHARED_CTRL(0),
      .COIN_PULSE(4), .COIN_GAP(6), .AF_HALF(3)
   ) dut_a (
      .clk_sys(clk), .reset(rst), .rotate(rotate), .kbjoy(kbjoy),
      .joy_in(joy_a), .af_enable(af_enable),
      .p_csjudlr(p_a), .coin_busy(busy_a)
   );

   arcade_ctrl_mapper #(
      .NPLAYERS(3), .SHARED_CTRL(1),
      .COIN_PULSE(4), .COIN_GAP(6), .AF_HALF(3)
   ) dut_b (
      .clk_sys(clk), .reset(rst), .rotate(rotate), .kbjoy(kbjoy),
      .joy_in(joy_b), .af_enable(af_enable),
      .p_csjudlr(p_b), .coin_busy(busy_b)
   );

   typedef struct {
      logic [1:0]  rot;
      logic [9:0]  kb;
      logic [15:0] ja;
      logic [23:0] jb;
      logic [13:0] ea;
      logic [20:0] eb;
   } vec_t;

   typedef struct {
      logic [13:0] ea;
      logic [20:0] eb;
   } exp_t;

   vec_t vt[14];
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin_chk(input string nm, input logic c, input logic b);
      chk({nm, " pa"}, 32'(p_a), 32'({7'h00, 1'b0, 6'h00} | (14'(c) << 6)));
      chk({nm, " pb"}, 32'(p_b), 32'(21'(c) << 6));
      chk({nm, " busy_a"}, 32'(busy_a), 32'(b));
      chk({nm, " busy_b"}, 32'(busy_b), 32'(b));
   endtask

   initial begin
      exp_t e;
      logic [11:0] pat;
      logic        c_exp;
      logic        b_exp;

      //            rot   kbjoy     joy_a     joy_b        exp_a     exp_b
      vt[0]  = '{2'd0, 10'h000, 16'h0000, 24'h000000, 14'h0000, 21'h000000};
      vt[1]  = '{2'd0, 10'h000, 16'h0008, 24'h000008, 14'h0008, 21'h020408};
      vt[2]  = '{2'd1, 10'h000, 16'h0008, 24'h000008, 14'h0001, 21'h004081};
      vt[3]  = '{2'd2, 10'h000, 16'h0008, 24'h000008, 14'h0004, 21'h010204};
      vt[4]  = '{2'd3, 10'h000, 16'h0008, 24'h000008, 14'h0002, 21'h008102};
      vt[5]  = '{2'd0, 10'h000, 16'h1000, 24'h001000, 14'h0800, 21'h040810};
      vt[6]  = '{2'd0, 10'h006, 16'h0000, 24'h000000, 14'h1020, 21'h001020};
      vt[7]  = '{2'd0, 10'h081, 16'h0000, 24'h000000, 14'h0011, 21'h044891};
      vt[8]  = '{2'd1, 10'h020, 16'h0000, 24'h000000, 14'h0002, 21'h008102};
      vt[9]  = '{2'd0, 10'h000, 16'h0200, 24'h020000, 14'h0100, 21'h008102};
      vt[10] = '{2'd2, 10'h000, 16'h0801, 24'h000801, 14'h0202, 21'h018306};
      vt[11] = '{2'd3, 10'h050, 16'h0000, 24'h000000, 14'h0006, 21'h018306};
      vt[12] = '{2'd0, 10'h300, 16'hE0E0, 24'hE0E0E0, 14'h0000, 21'h000000};
      vt[13] = '{2'd1, 10'h000, 16'h0000, 24'h000000, 14'h0000, 21'h000000};

      // reset held with random inputs
      rst       = 1'b1;
      af_enable = 1'b0;
      rotate    = 2'd0;
      kbjoy     = '0;
      joy_a     = '0;
      joy_b     = '0;
      for (int i = 0; i < 4; i++) begin
         rotate = 2'($urandom);
         kbjoy  = 10'($urandom);
         joy_a  = 16'($urandom);
         joy_b  = 24'($urandom);
         tick();
         chk("rst pa", 32'(p_a), 32'h0);
         chk("rst pb", 32'(p_b), 32'h0);
         chk("rst busy", 32'({busy_a, busy_b}), 32'h0);
      end
      rotate = 2'd0;
      kbjoy  = '0;
      joy_a  = 16'h0008;
      joy_b  = 24'h000008;
      rst    = 1'b0;
      tick();
      chk("post-rst pa", 32'(p_a), 32'h0008);
      chk("post-rst pb", 32'(p_b), 32'h020408);

      // mapping vectors through the scoreboard
      for (int i = 0; i < 14; i++) begin
         rotate = vt[i].rot;
         kbjoy  = vt[i].kb;
         joy_a  = vt[i].ja;
         joy_b  = vt[i].jb;
         e.ea   = vt[i].ea;
         e.eb   = vt[i].eb;
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         chk($sformatf("vec%0d pa", i), 32'(p_a), 32'(e.ea));
         chk($sformatf("vec%0d pb", i), 32'(p_b), 32'(e.eb));
      end
      chk("sb empty", 32'(sb.size()), 32'd0);

      // coin pulse / hold-off sequence
      rotate = 2'd0;
      kbjoy  = '0;
      joy_a  = '0;
      joy_b  = '0;
      tick();
      tick();
      for (int c = 0; c < 28; c++) begin
         c_exp = ((c >= 2) && (c <= 5)) || ((c >= 16) && (c <= 19));
         b_exp = ((c >= 2) && (c <= 11)) || ((c >= 16) && (c <= 25));
         if (c > 0)
            coin_chk($sformatf("coin c%0d", c), c_exp, b_exp);
         kbjoy[3] = ((c <= 2) || ((c >= 8) && (c <= 10)) ||
                     ((c >= 14) && (c <= 16)));
         tick();
      end

      // reset during the pulse, key held through release
      kbjoy = '0;
      repeat (3) tick();
      kbjoy = 10'h008;
      tick();
      tick();
      coin_chk("pre-rst pulse", 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      coin_chk("async rst", 1'b0, 1'b0);
      tick();
      tick();
      #2;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         coin_chk($sformatf("held-key c%0d", i), 1'b0, 1'b0);
      end
      kbjoy = '0;
      tick();
      kbjoy = 10'h008;
      tick();
      tick();
      coin_chk("re-press", 1'b1, 1'b1);
      kbjoy = '0;
      repeat (14) tick();

      // fire hold with autofire enable asserted
      af_enable = 1'b1;
      joy_a     = 16'h0010;
`ifdef AUTOFIRE_EN
      pat = 12'b111000111000;
`else
      pat = 12'b111111111111;
`endif
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("fire k%0d", k), 32'(p_a[4]), 32'(pat[12-k]));
      end
      joy_a = '0;
      tick();
      chk("fire release", 32'(p_a[4]), 32'h0);
      af_enable = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
